// File: rtl/game_datapath.sv
// Sprite game datapath: position/timer registers plus a queued square-sprite draw engine.
// Draw requests pass through a 2-deep FIFO with an empty-bypass so an idle engine starts in one cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNTW'(DEPTH));
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = (wr_q == LAST) ? '0 : wr_q + AW'(1);
    end
    if (do_pop) rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
    cnt_d = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

module game_datapath #(
  parameter int         TIMER_CYCLES = 1000000,
  parameter int         BLOCK        = 4,
  parameter int         X_INIT       = 0,
  parameter int         Y_INIT       = 0,
  parameter logic [2:0] FG_COLOUR    = 3'b111,
  parameter logic [2:0] BG_COLOUR    = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_xpos,
  input  logic [1:0] s_xpos,
  input  logic       en_ypos,
  input  logic [1:0] s_ypos,
  input  logic       en_timer,
  input  logic       s_timer,
  input  logic       plot,
  input  logic       s_color,
  output logic       timer_done,
  output logic [7:0] xpos,
  output logic [6:0] ypos,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       plot_overrun
);
  localparam int TW = $clog2(TIMER_CYCLES);
  localparam int CW = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam logic [7:0]    X_MAX = 8'(160 - BLOCK);
  localparam logic [6:0]    Y_MAX = 7'(120 - BLOCK);
  localparam logic [7:0]    X_RST = 8'(X_INIT);
  localparam logic [6:0]    Y_RST = 7'(Y_INIT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMER_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX = CW'(BLOCK - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t        state_q, state_d;
  logic [7:0]    xpos_q, xpos_d, base_x_q, base_x_d, vga_x_q, vga_x_d;
  logic [6:0]    ypos_q, ypos_d, base_y_q, base_y_d, vga_y_q, vga_y_d;
  logic [2:0]    colour_q, colour_d, vga_colour_q, vga_colour_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic          vga_plot_q, vga_plot_d, overrun_q, overrun_d;

  logic [17:0] req_dat, fifo_dat, src_dat;
  logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic        plot_ok, last_pix, take;

  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign timer_done   = (timer_q == T_MAX);
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign vga_colour   = vga_colour_q;
  assign vga_plot     = vga_plot_q;
  assign plot_overrun = overrun_q;
  assign busy         = !fifo_empty || (state_q == DRAW);

  always_comb begin
    xpos_d = xpos_q;
    if (en_xpos) begin
      case (s_xpos)
        2'd0:    xpos_d = X_RST;
        2'd1:    if (xpos_q < X_MAX) xpos_d = xpos_q + 8'd1;
        2'd2:    if (xpos_q != 8'd0) xpos_d = xpos_q - 8'd1;
        default: xpos_d = xpos_q;
      endcase
    end
    ypos_d = ypos_q;
    if (en_ypos) begin
      case (s_ypos)
        2'd0:    ypos_d = Y_RST;
        2'd1:    if (ypos_q < Y_MAX) ypos_d = ypos_q + 7'd1;
        2'd2:    if (ypos_q != 7'd0) ypos_d = ypos_q - 7'd1;
        default: ypos_d = ypos_q;
      endcase
    end
    timer_d = timer_q;
    if (en_timer) timer_d = !s_timer ? '0 : (timer_q != T_MAX) ? timer_q + TW'(1) : timer_q;
  end

  // An empty FIFO is bypassed: a free engine takes the incoming request directly.
  assign req_dat   = {xpos_q, ypos_q, s_color ? FG_COLOUR : BG_COLOUR};
  assign plot_ok   = plot && !fifo_full;
  assign last_pix  = (state_q == DRAW) && (col_q == C_MAX) && (row_q == C_MAX);
  assign take      = ((state_q == IDLE) || last_pix) && (!fifo_empty || plot_ok);
  assign fifo_pop  = take && !fifo_empty;
  assign fifo_push = plot_ok && !(take && fifo_empty);
  assign src_dat   = fifo_empty ? req_dat : fifo_dat;

  fifo #(.WIDTH(18), .DEPTH(2)) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (req_dat),
    .dout  (fifo_dat),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    colour_d = colour_q;
    col_d    = col_q;
    row_d    = row_q;
    if (take) begin
      state_d                        = DRAW;
      {base_x_d, base_y_d, colour_d} = src_dat;
      col_d                          = '0;
      row_d                          = '0;
    end else if ((state_q == DRAW) && !last_pix) begin
      if (col_q == C_MAX) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      state_d = IDLE;
    end
    vga_plot_d   = (state_d == DRAW);
    vga_x_d      = vga_plot_d ? base_x_d + 8'(col_d) : vga_x_q;
    vga_y_d      = vga_plot_d ? base_y_d + 7'(row_d) : vga_y_q;
    vga_colour_d = vga_plot_d ? colour_d : vga_colour_q;
    overrun_d    = overrun_q || (plot && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      xpos_q       <= X_RST;
      ypos_q       <= Y_RST;
      timer_q      <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      timer_q      <= timer_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      overrun_q    <= overrun_d;
    end
  end
endmodule
